uart_reg_loader: RTL and testbench
==================================

UART_REG_LOADER -- requirements
Module: uart_reg_loader

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, UART bit rate.
REQ-003 SHALL have parameter NUM_REGS, default 8, register count; legal range 1..8.
REQ-004 SHALL have parameter TIMEOUT_BITS, default 40, pending-nibble lifetime in bit times.
REQ-005 SHALL have port clk  input  1  sole clock; all state is on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port rx  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-008 SHALL have port regs  output  NUM_REGS*8  register file; register k occupies bits [8k+7:8k].
REQ-009 SHALL have port wr_stb  output  NUM_REGS  one-cycle commit pulse, bit k for register k.
REQ-010 SHALL have port rx_valid  output  1  one-cycle pulse per accepted byte.
REQ-011 SHALL have port rx_data  output  8  last accepted byte, held until the next one.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on a stop-bit error.
REQ-013 SHALL have port busy  output  1  high while the receiver is in any state other than IDLE.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-015 SHALL generate a 16x oversample tick every DIV = round(CLK_HZ/(BAUD*16)) clocks (78 at defaults); the divider restarts on leaving IDLE.
REQ-016 SHALL derive each bit value as the majority of samples at ticks 7, 8 and 9 of that bit.
REQ-017 SHALL implement receiver states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-018 IDLE -> START on a synchronized rx low.
REQ-019 START -> IDLE (false start, no output) if the start-bit vote is 1; otherwise START -> DATA.
REQ-020 DATA SHALL shift 8 bits, LSB first, at 16-tick intervals, then go to STOP.
REQ-021 STOP with vote 1 -> IDLE, updating rx_data and pulsing rx_valid one clock after the tick-9 sample.
REQ-022 STOP with vote 0 -> WAIT_IDLE, pulsing frame_err with no rx_valid and rx_data unchanged.
REQ-023 WAIT_IDLE -> IDLE only after synchronized rx has been high for 16 ticks.
REQ-024 SHALL decode each accepted byte as: addr = byte[7:5], hi = byte[4], nib = byte[3:0].
REQ-025 SHALL ignore bytes with addr >= NUM_REGS, leaving pending state untouched.
REQ-026 hi=0 SHALL load pending = {valid, addr, nib} and restart the timeout counter; a second low nibble overwrites the first.
REQ-027 hi=1 with pending valid and matching addr SHALL write regs[addr] = {nib, pending nib}, pulse wr_stb[addr], and clear pending.
REQ-028 The write in REQ-027 SHALL occur one clock after rx_valid; regs and wr_stb change in the same cycle.
REQ-029 hi=1 with no pending nibble, or with a mismatched addr, SHALL perform no write and clear pending.
REQ-030 Pending SHALL be cleared when TIMEOUT_BITS*16 ticks elapse after it was loaded without a commit.
REQ-031 A timeout and a commit in the same clock SHALL resolve as the commit.
REQ-032 At most one wr_stb bit SHALL be high in any cycle.

Reset
REQ-033 On reset: receiver state IDLE; divider, bit counter and timeout counter 0; pending cleared; regs, rx_data and wr_stb 0; rx_valid, frame_err and busy 0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame; after release, the next falling edge on rx starts a fresh frame.

Verification
REQ-035 Send bytes 0x27 then 0x3A -> rx_valid pulses twice; regs[1] = 0xA7; wr_stb[1] pulses exactly once.
REQ-036 Send 0x02, 0x18, 0x4C, 0x57, 0x69, 0x70 -> regs[0] = 0x82, regs[2] = 0x7C, regs[3] = 0x09; no other register changes.
REQ-037 Send 0x23 then 0x59 (addr mismatch) -> no wr_stb pulse; regs unchanged.
REQ-038 Send 0x4C, idle longer than 40 bit times, then send 0x57 -> no write; regs[2] unchanged.
REQ-039 Send a frame with stop bit 0 -> frame_err pulses once with no rx_valid; after rx is high for one bit time, 0x02 then 0x18 writes regs[0] = 0x82.
REQ-040 Drive a 2 us low glitch on rx -> no rx_valid or frame_err, busy returns to 0; assert reset at data bit 4 of 0x27 -> regs[1] stays 0 and the next full 0x27, 0x3A sequence writes 0xA7.

Source files
------------

// File: rtl/uart_reg_loader.sv
// 8N1 UART receiver feeding a nibble-pair register loader: a low-nibble byte arms a
// pending slot, and a matching high-nibble byte commits a full byte to one register.
module uart_reg_loader #(
    parameter int CLK_HZ       = 12000000,
    parameter int BAUD         = 9600,
    parameter int NUM_REGS     = 8,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic [NUM_REGS*8-1:0] regs,
    output logic [NUM_REGS-1:0]   wr_stb,
    output logic                  rx_valid,
    output logic [7:0]            rx_data,
    output logic                  frame_err,
    output logic                  busy
);
    localparam int DIV      = (CLK_HZ + BAUD * 8) / (BAUD * 16);
    localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TO_TICKS = TIMEOUT_BITS * 16;
    localparam int TO_W     = $clog2(TO_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_TICKS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    logic                rx_s1_q, rx_s2_q;
    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [3:0]          tick_cnt_q, tick_cnt_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [1:0]          samp_q, samp_d;
    logic [7:0]          shift_q, shift_d;
    logic [7:0]          rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                frame_err_q, frame_err_d;
    logic                pend_valid_q, pend_valid_d;
    logic [2:0]          pend_addr_q, pend_addr_d;
    logic [3:0]          pend_nib_q, pend_nib_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [7:0]          regs_q [NUM_REGS];
    logic [7:0]          regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_stb_q, wr_stb_d;
    logic                tick, vote;
    logic [2:0]          dec_addr;
    logic                dec_hi;
    logic [3:0]          dec_nib;

    assign tick     = (div_q == DIV_LAST);
    assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s2_q) | (samp_q[1] & rx_s2_q);
    assign dec_addr = rx_data_q[7:5];
    assign dec_hi   = rx_data_q[4];
    assign dec_nib  = rx_data_q[3:0];

    // NOTE: every signal gets its default before any branch so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        div_d       = tick ? '0 : div_q + DIV_W'(1);
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        samp_d      = samp_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        if (state_q != IDLE && tick) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
            if (tick_cnt_q == 4'd7) samp_d[0] = rx_s2_q;
            if (tick_cnt_q == 4'd8) samp_d[1] = rx_s2_q;
        end
        unique case (state_q)
            IDLE: if (!rx_s2_q) begin
                state_d    = START;
                div_d      = '0;
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
            end
            START: if (tick && tick_cnt_q == 4'd9 && vote) begin
                state_d = IDLE;
            end else if (tick && tick_cnt_q == 4'd15) begin
                state_d = DATA;
            end
            DATA: begin
                if (tick && tick_cnt_q == 4'd9) shift_d = {vote, shift_q[7:1]};
                if (tick && tick_cnt_q == 4'd15) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                end
            end
            STOP: if (tick && tick_cnt_q == 4'd9) begin
                if (vote) begin
                    state_d    = IDLE;
                    rx_data_d  = shift_q;
                    rx_valid_d = 1'b1;
                end else begin
                    state_d     = WAIT_IDLE;
                    frame_err_d = 1'b1;
                    tick_cnt_d  = '0;
                end
            end
            // Leave only after 16 consecutive high ticks; any low tick restarts the count.
            WAIT_IDLE: if (tick) begin
                if (!rx_s2_q)                 tick_cnt_d = '0;
                else if (tick_cnt_q == 4'd15) state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_nib_d   = pend_nib_q;
        to_cnt_d     = to_cnt_q;
        regs_d       = regs_q;
        wr_stb_d     = '0;
        if (pend_valid_q && tick) begin
            if (to_cnt_q == TO_LAST) pend_valid_d = 1'b0;
            else                     to_cnt_d     = to_cnt_q + TO_W'(1);
        end
        // Decoded bytes are applied after the expiry so a same-clock commit or reload wins.
        if (rx_valid_q && int'(dec_addr) < NUM_REGS) begin
            if (!dec_hi) begin
                pend_valid_d = 1'b1;
                pend_addr_d  = dec_addr;
                pend_nib_d   = dec_nib;
                to_cnt_d     = '0;
            end else begin
                pend_valid_d = 1'b0;
                if (pend_valid_q && pend_addr_q == dec_addr) begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (int'(dec_addr) == k) begin
                            regs_d[k]   = {dec_nib, pend_nib_q};
                            wr_stb_d[k] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            state_q      <= IDLE;
            div_q        <= '0;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            samp_q       <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_nib_q   <= '0;
            to_cnt_q     <= '0;
            wr_stb_q     <= '0;
            // NOTE: the register file is architecturally visible, so it is reset like any other flop.
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            rx_s1_q      <= rx;
            rx_s2_q      <= rx_s1_q;
            state_q      <= state_d;
            div_q        <= div_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_nib_q   <= pend_nib_d;
            to_cnt_q     <= to_cnt_d;
            wr_stb_q     <= wr_stb_d;
            regs_q       <= regs_d;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
        assign regs[k*8 +: 8] = regs_q[k];
    end

    assign wr_stb    = wr_stb_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_reg_loader.sv
// Scoreboarded bench for uart_reg_loader: a transaction-level model predicts accepted
// bytes and register commits, and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_uart_reg_loader;
    localparam int CLK_HZ       = 1_600_000;
    localparam int BAUD         = 10_000;
    localparam int NUM_REGS     = 8;
    localparam int TIMEOUT_BITS = 40;
    localparam int DIV          = (CLK_HZ + BAUD * 8) / (BAUD * 16);
    localparam int BIT_CLKS     = DIV * 16;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  rx = 1'b1;
    logic [NUM_REGS*8-1:0] regs;
    logic [NUM_REGS-1:0]   wr_stb;
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  frame_err;
    logic                  busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    int n_wr     = 0;
    int n_ferr   = 0;

    logic [7:0]  exp_rx_q [$];
    logic [10:0] exp_wr_q [$];
    logic [7:0]  model_regs [NUM_REGS];
    logic        m_pv;
    logic [2:0]  m_pa;
    logic [3:0]  m_pn;

    uart_reg_loader #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .NUM_REGS(NUM_REGS), .TIMEOUT_BITS(TIMEOUT_BITS)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .regs(regs), .wr_stb(wr_stb),
        .rx_valid(rx_valid), .rx_data(rx_data), .frame_err(frame_err), .busy(busy)
    );

    always #312.5 clk = ~clk;  // 1.6 MHz

    task automatic model_clear();
        for (int k = 0; k < NUM_REGS; k++) model_regs[k] = 8'h00;
        m_pv = 1'b0;
        m_pa = 3'd0;
        m_pn = 4'd0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [2:0] a;
        a = b[7:5];
        exp_rx_q.push_back(b);
        if (int'(a) < NUM_REGS) begin
            if (!b[4]) begin
                m_pv = 1'b1;
                m_pa = a;
                m_pn = b[3:0];
            end else begin
                if (m_pv && m_pa == a) begin
                    model_regs[a] = {b[3:0], m_pn};
                    exp_wr_q.push_back({a, b[3:0], m_pn});
                end
                m_pv = 1'b0;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        send_frame(b, 1'b1);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    task automatic monitor();
        logic [7:0]          eb;
        logic [10:0]         ew;
        logic [NUM_REGS-1:0] oh;
        forever begin
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                n_valid++;
                n_checks++;
                if (exp_rx_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL rx_valid_unexpected: got byte %02h, expected no byte", rx_data);
                end else begin
                    eb = exp_rx_q.pop_front();
                    if (rx_data !== eb) begin
                        n_errors++;
                        $display("FAIL rx_data: got %02h, expected %02h", rx_data, eb);
                    end
                end
            end
            if (frame_err === 1'b1) n_ferr++;
            if (wr_stb !== '0) begin
                n_wr++;
                n_checks++;
                if (exp_wr_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL wr_stb_unexpected: got %b, expected no write", wr_stb);
                end else begin
                    ew = exp_wr_q.pop_front();
                    oh = '0;
                    oh[ew[10:8]] = 1'b1;
                    if (wr_stb !== oh || regs[ew[10:8]*8 +: 8] !== ew[7:0]) begin
                        n_errors++;
                        $display("FAIL write: got stb %b reg %02h, expected stb %b reg %02h",
                                 wr_stb, regs[ew[10:8]*8 +: 8], oh, ew[7:0]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rx = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 6;
        if (regs !== '0)      begin n_errors++; $display("FAIL reset_regs: got %h, expected 0", regs); end
        if (wr_stb !== '0)    begin n_errors++; $display("FAIL reset_wr_stb: got %b, expected 0", wr_stb); end
        if (rx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rx_valid: got %b, expected 0", rx_valid); end
        if (frame_err !== 1'b0) begin n_errors++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err); end
        if (busy !== 1'b0)    begin n_errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        if (rx_data !== 8'h00) begin n_errors++; $display("FAIL reset_rx_data: got %02h, expected 00", rx_data); end
        reset = 1'b0;
        model_clear();
        idle_bits(1);
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL idle_busy: got %b, expected 0", busy); end
    endtask

    task automatic test_single_pair();
        int v0, w0;
        v0 = n_valid;
        w0 = n_wr;
        send_byte(8'h27);
        send_byte(8'h3A);
        idle_bits(1);
        n_checks += 4;
        if (n_valid - v0 != 2) begin n_errors++; $display("FAIL pair_valid_count: got %0d, expected 2", n_valid - v0); end
        if (n_wr - w0 != 1)    begin n_errors++; $display("FAIL pair_wr_count: got %0d, expected 1", n_wr - w0); end
        if (regs[15:8] !== 8'hA7) begin n_errors++; $display("FAIL pair_reg1: got %02h, expected a7", regs[15:8]); end
        if (exp_rx_q.size() + exp_wr_q.size() != 0) begin
            n_errors++;
            $display("FAIL pair_drain: got %0d outstanding, expected 0", exp_rx_q.size() + exp_wr_q.size());
        end
    endtask

    task automatic test_multi_regs();
        int w0;
        logic [7:0] seq [6];
        seq = '{8'h02, 8'h18, 8'h4C, 8'h57, 8'h69, 8'h70};
        w0 = n_wr;
        foreach (seq[i]) send_byte(seq[i]);
        idle_bits(1);
        n_checks += 4;
        if (n_wr - w0 != 3)       begin n_errors++; $display("FAIL multi_wr_count: got %0d, expected 3", n_wr - w0); end
        if (regs[7:0] !== 8'h82)  begin n_errors++; $display("FAIL multi_reg0: got %02h, expected 82", regs[7:0]); end
        if (regs[23:16] !== 8'h7C) begin n_errors++; $display("FAIL multi_reg2: got %02h, expected 7c", regs[23:16]); end
        if (regs[31:24] !== 8'h09) begin n_errors++; $display("FAIL multi_reg3: got %02h, expected 09", regs[31:24]); end
        for (int k = 0; k < NUM_REGS; k++) begin
            n_checks++;
            if (regs[k*8 +: 8] !== model_regs[k]) begin
                n_errors++;
                $display("FAIL multi_reg_file[%0d]: got %02h, expected %02h", k, regs[k*8 +: 8], model_regs[k]);
            end
        end
    endtask

    task automatic test_addr_mismatch();
        int w0;
        w0 = n_wr;
        send_byte(8'h23);
        send_byte(8'h59);
        idle_bits(1);
        n_checks++;
        if (n_wr - w0 != 0) begin n_errors++; $display("FAIL mismatch_wr_count: got %0d, expected 0", n_wr - w0); end
        for (int k = 0; k < NUM_REGS; k++) begin
            n_checks++;
            if (regs[k*8 +: 8] !== model_regs[k]) begin
                n_errors++;
                $display("FAIL mismatch_reg_file[%0d]: got %02h, expected %02h", k, regs[k*8 +: 8], model_regs[k]);
            end
        end
    endtask

    task automatic test_timeout();
        int w0;
        w0 = n_wr;
        send_byte(8'h4C);
        idle_bits(TIMEOUT_BITS + 5);
        m_pv = 1'b0;
        send_byte(8'h57);
        idle_bits(1);
        n_checks += 3;
        if (n_wr - w0 != 0)        begin n_errors++; $display("FAIL timeout_wr_count: got %0d, expected 0", n_wr - w0); end
        if (regs[23:16] !== 8'h7C) begin n_errors++; $display("FAIL timeout_reg2: got %02h, expected 7c", regs[23:16]); end
        if (exp_rx_q.size() != 0)  begin n_errors++; $display("FAIL timeout_drain: got %0d outstanding, expected 0", exp_rx_q.size()); end
    endtask

    task automatic test_frame_err();
        int v0, w0, f0;
        v0 = n_valid;
        w0 = n_wr;
        f0 = n_ferr;
        send_frame(8'hA5, 1'b0);
        rx = 1'b1;
        repeat (BIT_CLKS + 4 * DIV) @(negedge clk);
        n_checks += 3;
        if (n_ferr - f0 != 1)    begin n_errors++; $display("FAIL ferr_count: got %0d, expected 1", n_ferr - f0); end
        if (n_valid - v0 != 0)   begin n_errors++; $display("FAIL ferr_valid_count: got %0d, expected 0", n_valid - v0); end
        if (rx_data !== 8'h57)   begin n_errors++; $display("FAIL ferr_rx_data_held: got %02h, expected 57", rx_data); end
        send_byte(8'h02);
        send_byte(8'h18);
        idle_bits(1);
        n_checks += 3;
        if (n_valid - v0 != 2)   begin n_errors++; $display("FAIL ferr_recover_valid: got %0d, expected 2", n_valid - v0); end
        if (n_wr - w0 != 1)      begin n_errors++; $display("FAIL ferr_recover_wr: got %0d, expected 1", n_wr - w0); end
        if (regs[7:0] !== 8'h82) begin n_errors++; $display("FAIL ferr_recover_reg0: got %02h, expected 82", regs[7:0]); end
    endtask

    task automatic test_glitch_and_reset();
        int v0, w0, f0, waited;
        logic [7:0] b;
        v0 = n_valid;
        f0 = n_ferr;
        rx = 1'b0;
        #2000;
        rx = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL glitch_busy_rise: got %b, expected 1", busy); end
        waited = 0;
        while (busy !== 1'b0 && waited < 4 * BIT_CLKS) begin
            @(negedge clk);
            waited++;
        end
        n_checks += 3;
        if (busy !== 1'b0)     begin n_errors++; $display("FAIL glitch_busy_fall: got %b after %0d clocks, expected 0", busy, waited); end
        if (n_valid - v0 != 0) begin n_errors++; $display("FAIL glitch_valid: got %0d, expected 0", n_valid - v0); end
        if (n_ferr - f0 != 0)  begin n_errors++; $display("FAIL glitch_ferr: got %0d, expected 0", n_ferr - f0); end

        b = 8'h27;
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = b[4];
        repeat (BIT_CLKS / 2) @(negedge clk);
        reset = 1'b1;
        rx = 1'b1;
        repeat (4) @(negedge clk);
        n_checks += 2;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL midframe_reset_busy: got %b, expected 0", busy); end
        if (regs !== '0)   begin n_errors++; $display("FAIL midframe_reset_regs: got %h, expected 0", regs); end
        reset = 1'b0;
        model_clear();
        idle_bits(2);
        n_checks++;
        if (regs[15:8] !== 8'h00) begin n_errors++; $display("FAIL midframe_reg1: got %02h, expected 00", regs[15:8]); end
        w0 = n_wr;
        send_byte(8'h27);
        send_byte(8'h3A);
        idle_bits(1);
        n_checks += 3;
        if (n_wr - w0 != 1)       begin n_errors++; $display("FAIL after_reset_wr: got %0d, expected 1", n_wr - w0); end
        if (regs[15:8] !== 8'hA7) begin n_errors++; $display("FAIL after_reset_reg1: got %02h, expected a7", regs[15:8]); end
        if (exp_rx_q.size() + exp_wr_q.size() != 0) begin
            n_errors++;
            $display("FAIL final_drain: got %0d outstanding, expected 0", exp_rx_q.size() + exp_wr_q.size());
        end
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        fork
            monitor();
        join_none
        test_reset();
        test_single_pair();
        test_multi_regs();
        test_addr_mismatch();
        test_timeout();
        test_frame_err();
        test_glitch_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
